// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding,
// release-phase length and a small helper for the busy indication.
package cpu_run_controller_pkg;

  // One program run walks IDLE -> LOAD -> RELEASE -> RUN -> DUMP -> DONE.
  // LOAD is skipped when the run re-uses the existing imem contents.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DUMP    = 3'd4,
    ST_DONE    = 3'd5
  } run_state_t;

  // Cycles the CPU is kept in reset after the image is in place, so the
  // datapath settles on a clean PC before it is let go.
  localparam int RELEASE_CYCLES = 3;
  localparam int RCNT_W         = 2;

  // Busy covers every state in which a run is in progress.
  function automatic logic state_busy(input run_state_t s);
    return (s == ST_LOAD) || (s == ST_RELEASE) || (s == ST_RUN) || (s == ST_DUMP);
  endfunction

endpackage

// File: rtl/cpu_run_controller_stream_out_slice.sv
// Output register of a valid/ready stream. The owner asserts load only when
// can_load is high; the slice then holds valid/data until the sink takes it.
//
// Handshake: a word transfers on a rising edge where valid && ready are both
// high. While valid is high and ready is low, valid and data do not change.
// A new word may be loaded in the same cycle the current one is accepted,
// giving one word per cycle when ready stays high.
module stream_out_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         can_load
);

  // The register is free when empty or when its word leaves this cycle.
  assign can_load = !valid || ready;

  // Load a new word, otherwise drain on acceptance, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences one program run of the single-cycle CPU: streams a program image
// into imem with the CPU held in reset, releases the CPU, watches PC for the
// end address (or a cycle timeout), re-freezes the CPU and streams a window
// of data RAM out through a valid/ready port.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int          IAW       = 8,
  parameter int          DAW       = 8,
  parameter logic [31:0] END_PC    = 32'd48,
  parameter int          DUMP_BASE = 16,
  parameter int          DUMP_LEN  = 15,
  parameter int          TIMEOUT   = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [IAW:0]   prog_len,
  input  logic           ld_valid,
  input  logic [31:0]    ld_data,
  output logic           ld_ready,
  output logic           imem_we,
  output logic [IAW-1:0] imem_waddr,
  output logic [31:0]    imem_wdata,
  output logic           cpu_reset,
  input  logic [31:0]    pc,
  output logic [DAW-1:0] dmem_raddr,
  input  logic [31:0]    dmem_rdata,
  output logic           out_valid,
  output logic [31:0]    out_data,
  input  logic           out_ready,
  output logic           busy,
  output logic           done,
  output logic           timed_out,
  output logic [2:0]     state_dbg
);

  localparam int CYC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int IDX_W = $clog2(DUMP_LEN + 1);

  run_state_t         state;
  run_state_t         state_nxt;
  logic [IAW:0]       plen;
  logic [IAW:0]       wcnt;
  logic [RCNT_W-1:0]  rcnt;
  logic [CYC_W-1:0]   cyc;
  logic [IDX_W-1:0]   idx;

  logic start_ok;
  logic ld_fire;
  logic load_last;
  logic release_last;
  logic end_hit;
  logic to_hit;
  logic can_load;
  logic dump_load;
  logic dump_last;

  // ---------------------------------------------------------------------
  // Datapath decodes
  // ---------------------------------------------------------------------
  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign ld_ready     = (state == ST_LOAD);
  assign ld_fire      = ld_valid && ld_ready;
  assign load_last    = ld_fire && (wcnt == plen - 1'b1);
  assign release_last = (rcnt == RCNT_W'(RELEASE_CYCLES - 1));

  // Unsigned compare: a PC that has run far past the end still ends the run.
  assign end_hit      = (pc >= END_PC);
  assign to_hit       = (cyc == CYC_W'(TIMEOUT - 1));

  // imem write port follows the load handshake combinationally.
  assign imem_we      = ld_fire;
  assign imem_waddr   = wcnt[IAW-1:0];
  assign imem_wdata   = ld_data;

  // The CPU only runs in RUN; it is frozen while loading and dumping.
  assign cpu_reset    = (state != ST_RUN);

  // The dump address tracks the next word to be captured; dmem reads
  // asynchronously so the data is registered in the same cycle.
  assign dmem_raddr   = DAW'(DUMP_BASE) + DAW'(idx);
  assign dump_load    = (state == ST_DUMP) && can_load && (idx < IDX_W'(DUMP_LEN));

  // Once every word has been captured, the one held in the slice is the last.
  assign dump_last    = (state == ST_DUMP) && (idx == IDX_W'(DUMP_LEN)) &&
                        out_valid && out_ready;

  assign busy         = state_busy(state);
  assign done         = (state == ST_DONE);
  assign state_dbg    = state;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_nxt = (prog_len != '0) ? ST_LOAD : ST_RELEASE;
        end
      end
      ST_LOAD: begin
        if (load_last) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (release_last) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (end_hit || to_hit) begin
          state_nxt = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (dump_last) begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counters and run status. Each counter is cleared when a run starts and
  // only advances in its own state, which it leaves before it could wrap.
  // ---------------------------------------------------------------------

  // Per-run counters, the sampled program length and the timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plen      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      cyc       <= '0;
      idx       <= '0;
      timed_out <= 1'b0;
    end else if (start_ok) begin
      plen      <= prog_len;
      wcnt      <= '0;
      rcnt      <= '0;
      cyc       <= '0;
      idx       <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_fire) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!release_last) begin
            rcnt <= rcnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!end_hit && !to_hit) begin
            cyc <= cyc + 1'b1;
          end
          // Reaching the end address in the timeout cycle is a clean finish.
          if (!end_hit && to_hit) begin
            timed_out <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (dump_load) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Dump output register
  // ---------------------------------------------------------------------
  stream_out_slice #(
    .W (32)
  ) u_out_slice (
    .clk       (clk),
    .reset     (reset),
    .load      (dump_load),
    .load_data (dmem_rdata),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller. A behavioural stand-in for the CPU produces
// PC values from a per-run "jump" cycle; dmem is a bench array. Expected
// imem writes, release length, run length, timeout flag and dump contents
// are computed from the run parameters.
module tb_cpu_run_controller;

  localparam int IAW       = 8;
  localparam int DAW       = 8;
  localparam int DUMP_BASE = 16;
  localparam int DUMP_LEN  = 15;
  localparam int TIMEOUT   = 64;
  localparam int REL_CYC   = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [IAW:0]   prog_len = '0;
  logic           ld_valid = 1'b0;
  logic [31:0]    ld_data = '0;
  logic           ld_ready;
  logic           imem_we;
  logic [IAW-1:0] imem_waddr;
  logic [31:0]    imem_wdata;
  logic           cpu_reset;
  logic [31:0]    pc;
  logic [DAW-1:0] dmem_raddr;
  logic [31:0]    dmem_rdata;
  logic           out_valid;
  logic [31:0]    out_data;
  logic           out_ready = 1'b1;
  logic           busy;
  logic           done;
  logic           timed_out;
  logic [2:0]     state_dbg;

  cpu_run_controller #(
    .IAW       (IAW),
    .DAW       (DAW),
    .END_PC    (32'd48),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LEN  (DUMP_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .pc         (pc),
    .dmem_raddr (dmem_raddr),
    .dmem_rdata (dmem_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- CPU stand-in and data RAM ----------------
  int unsigned rc = 0;          // cycles since CPU left reset
  int unsigned jump_at = 1000;  // RUN cycle at which PC reaches the end region
  logic        pc_hi = 1'b0;    // end region reached by a very large PC
  logic [31:0] dmem [0:255];
  logic [31:0] prog [0:511];

  always @(posedge clk) begin
    if (cpu_reset) rc <= 0;
    else           rc <= rc + 1;
  end

  always_comb begin
    if (rc >= jump_at) pc = pc_hi ? 32'h8000_0000 : 32'd48 + 32'(4 * (rc - jump_at));
    else               pc = 32'((rc * 4) % 48);
  end

  assign dmem_rdata = dmem[dmem_raddr];

  // ---------------- monitor state ----------------
  logic [IAW-1:0] wr_addr_q [$];
  logic [31:0]    wr_data_q [$];
  logic [31:0]    got_q [$];
  int             run_cycles = 0;
  int             valid_cycles = 0;
  int             gap = 0;
  int             rel_gap = -1;
  bit             gap_armed = 1'b0;
  bit             prev_stall = 1'b0;
  logic [31:0]    prev_data = '0;
  int             rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe the DUT on the falling edge.
  initial forever begin
    @(negedge clk);
    if (imem_we) begin
      wr_addr_q.push_back(imem_waddr);
      wr_data_q.push_back(imem_wdata);
    end
    if (!cpu_reset) run_cycles++;
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (start && !busy) begin
      gap_armed = 1'b1;
      gap = 0;
    end else if (imem_we) begin
      gap = 0;
    end else if (gap_armed && cpu_reset) begin
      gap++;
    end else if (gap_armed && !cpu_reset) begin
      rel_gap = gap;
      gap_armed = 1'b0;
    end
    if (prev_stall) begin
      checks++;
      assert (out_valid === 1'b1 && out_data === prev_data) else begin
        errors++;
        $error("FAIL stall_hold: observed valid=%0b data=%0h expected valid=1 data=%0h",
               out_valid, out_data, prev_data);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  // Sink readiness: always, random, or a 4-cycle stall after 3 dump words.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = !(valid_cycles >= 3 && valid_cycles <= 6);
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    prog_len = (IAW + 1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offer words with a toggling valid until cnt words have been accepted.
  task automatic load_words(input int cnt);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < cnt && guard < 2000) begin
      ld_valid = ($urandom_range(0, 1) != 0);
      ld_data = prog[i];
      @(negedge clk);
      acc = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    ld_valid = 1'b0;
    check("load_complete", 32'(i), 32'(cnt));
  endtask

  // One full run: expected behaviour follows from n, j and the window.
  task automatic do_run(input int n, input int j, input bit hi, input int mode,
                        input bit fib, input bit start_in_run);
    int t;
    int exp_run;
    logic [31:0] exp_q [$];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    for (int i = 0; i < n; i++) prog[i] = $urandom;
    a = 32'd1;
    b = 32'd1;
    for (int i = 0; i < DUMP_LEN; i++) begin
      if (fib) begin
        dmem[DUMP_BASE + i] = a;
        c = a + b;
        a = b;
        b = c;
      end else begin
        dmem[DUMP_BASE + i] = $urandom;
      end
      exp_q.push_back(dmem[DUMP_BASE + i]);
    end
    jump_at = j;
    pc_hi = hi;
    rdy_mode = mode;
    wr_addr_q.delete();
    wr_data_q.delete();
    got_q.delete();
    run_cycles = 0;
    valid_cycles = 0;
    rel_gap = -1;

    pulse_start(n);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_to_clr", 32'(timed_out), 32'd0);
    if (n > 0) load_words(n);

    if (start_in_run) begin
      t = 0;
      while (cpu_reset !== 1'b0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("reach_run", 32'(cpu_reset), 32'd0);
      pulse_start(5);
    end

    t = 0;
    while (done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 32'(done), 32'd1);

    check("imem_wr_count", 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check("imem_waddr", 32'(wr_addr_q[i]), 32'(i));
      check("imem_wdata", wr_data_q[i], prog[i]);
    end
    check("release_cycles", 32'(rel_gap), 32'(REL_CYC));
    exp_run = ((j < TIMEOUT - 1) ? j : TIMEOUT - 1) + 1;
    check("run_cycles", 32'(run_cycles), 32'(exp_run));
    check("timed_out", 32'(timed_out), (j > TIMEOUT - 1) ? 32'd1 : 32'd0);
    check("dump_count", 32'(got_q.size()), 32'(DUMP_LEN));
    for (int i = 0; i < DUMP_LEN && i < got_q.size(); i++) begin
      check("dump_word", got_q[i], exp_q[i]);
    end
    if (mode == 0) check("dump_throughput", 32'(valid_cycles), 32'(DUMP_LEN));
    check("done_cpu_reset", 32'(cpu_reset), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("done_held", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_before;
    for (int i = 0; i < 256; i++) dmem[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    reset = 1'b1;

    // Reset in the middle of a 10-word load
    for (int i = 0; i < 10; i++) prog[i] = $urandom;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(10);
    load_words(5);
    reset = 1'b0;
    #1;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    n_before = wr_addr_q.size();
    ld_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_ld_ready_after", 32'(ld_ready), 32'd0);
    check("midrst_busy_after", 32'(busy), 32'd0);
    ld_valid = 1'b0;
    @(negedge clk);
    check("midrst_no_writes", 32'(wr_addr_q.size()), 32'(n_before));
    check("midrst_wr_count", 32'(n_before), 32'd5);

    // Fibonacci window, 12-word image, PC reaches 48 at RUN cycle 12
    do_run(12, 12, 1'b0, 0, 1'b1, 1'b0);
    // Sink stalls 4 cycles mid-dump
    do_run(7, 20, 1'b0, 2, 1'b0, 1'b0);
    // start while running is ignored
    do_run(4, 40, 1'b0, 1, 1'b0, 1'b1);
    // PC never reaches the end: timeout after 64 RUN cycles
    do_run(3, 500, 1'b0, 1, 1'b0, 1'b0);
    // Restart from DONE without loading; end address and timeout coincide
    do_run(0, TIMEOUT - 1, 1'b1, 0, 1'b0, 1'b0);
    // One cycle short of the timeout, and one cycle past it
    do_run(2, TIMEOUT - 2, 1'b0, 0, 1'b0, 1'b0);
    do_run(1, TIMEOUT, 1'b1, 1, 1'b0, 1'b0);
    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      do_run($urandom_range(0, 20), $urandom_range(0, 80), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
